uart_tx_mmio: RTL

Memory-mapped UART transmitter on the single-cycle core's data bus, downstream of the core's store path. It decodes `HADDR`/`MemWrite`/write data and buffers bytes in a small FIFO. A baud-timed 8N1 state machine serialises the bytes onto `tx`. It returns status and divisor reads on `HRDATA` combinationally, and asserts `hit` so the parent can steer `HRDATA_Data`.

---
 rtl/uart_tx_mmio.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter for the core data bus.
// Stores to TXDATA are queued in a small FIFO and serialised LSB-first onto
// tx. STATUS and DIV read back combinationally. hit tells the parent that
// HRDATA belongs to this block.
module uart_tx_mmio #(
  parameter int unsigned LENGTH       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LENGTH-1:0] HADDR,
  input  logic              MemWrite,
  input  logic [LENGTH-1:0] WDATA,
  output logic [LENGTH-1:0] HRDATA,
  output logic              hit,
  output logic              tx,
  output logic              tx_busy
);

  localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RST  = 16'(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FSM and serialiser state
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_act_q, div_act_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  // Register file and FIFO state
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  // Bus decode and FIFO handshake
  logic       wr_en;
  logic [1:0] sel;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic       bit_end;
  logic [3:0] count4;
  logic [7:0] status_byte;

  // Low address bits and upper store data bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{HADDR[1:0], WDATA[LENGTH-1:16]};

  assign hit     = (HADDR[LENGTH-1:4] == BASE_ADDR[LENGTH-1:4]);
  assign tx      = tx_q;
  assign tx_busy = busy_q;

  // Decode stores, and decide pushes and pops for this cycle
  always_comb begin
    wr_en      = MemWrite & hit;
    sel        = HADDR[3:2];
    push_req   = wr_en && (sel == 2'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    bit_end    = (baud_q == 16'd0);
    // A frame starts from IDLE, or directly from the last STOP cycle.
    pop        = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    // A full FIFO still accepts a push in the cycle a byte leaves it.
    push_ok    = push_req && (!fifo_full || pop);
  end

  // FIFO storage, pointers, count and register-file next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = WDATA[7:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (wr_en && (sel == 2'd1) && WDATA[3]) begin
      ovf_d = 1'b0;
    end

    // A divisor below 2 cannot time a bit, so such writes are discarded.
    if (wr_en && (sel == 2'd2) && (WDATA[15:0] >= 16'd2)) begin
      div_d = WDATA[15:0];
    end
  end

  // Serialiser FSM next state: START, 8 DATA bits LSB first, STOP
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_act_d = div_act_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = div_act_q - 16'd1;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = div_act_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame start overrides the IDLE/STOP defaults; the divisor is frozen
    // here so a DIV write mid-frame only affects later frames.
    if (pop) begin
      state_d   = S_START;
      shift_d   = mem_q[rd_ptr_q];
      div_act_d = div_q;
      baud_d    = div_q - 16'd1;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  // Combinational read mux for STATUS and DIV
  always_comb begin
    count4      = 4'(count_q);
    status_byte = {count4, ovf_q, fifo_empty, fifo_full, busy_q};
    HRDATA      = '0;
    if (hit) begin
      unique case (sel)
        2'd1:    HRDATA[7:0]  = status_byte;
        2'd2:    HRDATA[15:0] = div_q;
        default: HRDATA       = '0;
      endcase
    end
  end

  // Control registers with synchronous active-low reset; reset abandons any frame
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      div_q    <= DIV_RST;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data registers carry no reset; they are always loaded before use
  always_ff @(posedge clock) begin
    shift_q   <= shift_d;
    div_act_q <= div_act_d;
    mem_q     <= mem_d;
  end

endmodule
